async_queue_sink_ctrl: RTL



---
 rtl/debug_ctrl_pkg.sv | 17 +
 rtl/async_queue_sink_ctrl_if.sv | 69 ++++++
 rtl/async_sync_reg.sv | 20 ++
 rtl/async_queue_sink_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/debug_ctrl_pkg.sv
// Shared types and defaults for the debug-module hart-control async queue.
// The control bundle is packed MSB-first in the field order listed below.
package debug_ctrl_pkg;

  localparam int unsigned SYNC_DEPTH_DEFAULT = 3;
  localparam int unsigned CTRL_W             = 25;

  typedef struct packed {
    logic       resumereq;
    logic [9:0] hartsel;
    logic       ackhavereset;
    logic       hasel;
    logic [5:0] hamask;
    logic [5:0] hrmask;
  } ctrl_bundle_t;

endpackage

// File: rtl/async_queue_sink_ctrl_if.sv
// Signal bundle between the control async-queue source/consumer side (master)
// and the sink (slave). dbg_* expose internal sink state for observation.
interface async_queue_sink_ctrl_if;

  logic       io_async_mem_0_resumereq;
  logic [9:0] io_async_mem_0_hartsel;
  logic       io_async_mem_0_ackhavereset;
  logic       io_async_mem_0_hasel;
  logic       io_async_mem_0_hamask_0, io_async_mem_0_hamask_1, io_async_mem_0_hamask_2;
  logic       io_async_mem_0_hamask_3, io_async_mem_0_hamask_4, io_async_mem_0_hamask_5;
  logic       io_async_mem_0_hrmask_0, io_async_mem_0_hrmask_1, io_async_mem_0_hrmask_2;
  logic       io_async_mem_0_hrmask_3, io_async_mem_0_hrmask_4, io_async_mem_0_hrmask_5;
  logic       io_async_widx;
  logic       io_async_safe_widx_valid;
  logic       io_async_safe_source_reset_n;
  logic       io_deq_ready;

  logic       io_deq_valid;
  logic       io_deq_bits_resumereq;
  logic [9:0] io_deq_bits_hartsel;
  logic       io_deq_bits_ackhavereset;
  logic       io_deq_bits_hasel;
  logic       io_deq_bits_hamask_0, io_deq_bits_hamask_1, io_deq_bits_hamask_2;
  logic       io_deq_bits_hamask_3, io_deq_bits_hamask_4, io_deq_bits_hamask_5;
  logic       io_deq_bits_hrmask_0, io_deq_bits_hrmask_1, io_deq_bits_hrmask_2;
  logic       io_deq_bits_hrmask_3, io_deq_bits_hrmask_4, io_deq_bits_hrmask_5;
  logic       io_async_ridx;
  logic       io_async_safe_ridx_valid;
  logic       io_async_safe_sink_reset_n;
  logic       dbg_source_ready;
  logic       dbg_ridx_bin;

  modport slave (
    input  io_async_mem_0_resumereq, io_async_mem_0_hartsel, io_async_mem_0_ackhavereset,
           io_async_mem_0_hasel,
           io_async_mem_0_hamask_0, io_async_mem_0_hamask_1, io_async_mem_0_hamask_2,
           io_async_mem_0_hamask_3, io_async_mem_0_hamask_4, io_async_mem_0_hamask_5,
           io_async_mem_0_hrmask_0, io_async_mem_0_hrmask_1, io_async_mem_0_hrmask_2,
           io_async_mem_0_hrmask_3, io_async_mem_0_hrmask_4, io_async_mem_0_hrmask_5,
           io_async_widx, io_async_safe_widx_valid, io_async_safe_source_reset_n, io_deq_ready,
    output io_deq_valid, io_deq_bits_resumereq, io_deq_bits_hartsel, io_deq_bits_ackhavereset,
           io_deq_bits_hasel,
           io_deq_bits_hamask_0, io_deq_bits_hamask_1, io_deq_bits_hamask_2,
           io_deq_bits_hamask_3, io_deq_bits_hamask_4, io_deq_bits_hamask_5,
           io_deq_bits_hrmask_0, io_deq_bits_hrmask_1, io_deq_bits_hrmask_2,
           io_deq_bits_hrmask_3, io_deq_bits_hrmask_4, io_deq_bits_hrmask_5,
           io_async_ridx, io_async_safe_ridx_valid, io_async_safe_sink_reset_n,
           dbg_source_ready, dbg_ridx_bin
  );

  modport master (
    output io_async_mem_0_resumereq, io_async_mem_0_hartsel, io_async_mem_0_ackhavereset,
           io_async_mem_0_hasel,
           io_async_mem_0_hamask_0, io_async_mem_0_hamask_1, io_async_mem_0_hamask_2,
           io_async_mem_0_hamask_3, io_async_mem_0_hamask_4, io_async_mem_0_hamask_5,
           io_async_mem_0_hrmask_0, io_async_mem_0_hrmask_1, io_async_mem_0_hrmask_2,
           io_async_mem_0_hrmask_3, io_async_mem_0_hrmask_4, io_async_mem_0_hrmask_5,
           io_async_widx, io_async_safe_widx_valid, io_async_safe_source_reset_n, io_deq_ready,
    input  io_deq_valid, io_deq_bits_resumereq, io_deq_bits_hartsel, io_deq_bits_ackhavereset,
           io_deq_bits_hasel,
           io_deq_bits_hamask_0, io_deq_bits_hamask_1, io_deq_bits_hamask_2,
           io_deq_bits_hamask_3, io_deq_bits_hamask_4, io_deq_bits_hamask_5,
           io_deq_bits_hrmask_0, io_deq_bits_hrmask_1, io_deq_bits_hrmask_2,
           io_deq_bits_hrmask_3, io_deq_bits_hrmask_4, io_deq_bits_hrmask_5,
           io_async_ridx, io_async_safe_ridx_valid, io_async_safe_sink_reset_n,
           dbg_source_ready, dbg_ridx_bin
  );

endinterface

// File: rtl/async_sync_reg.sv
// DEPTH-flop single-bit synchronizer, asynchronously cleared to 0.
module async_sync_reg #(
  parameter int unsigned DEPTH = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [DEPTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '0;
    else         sync_q <= {sync_q[DEPTH-2:0], d_i};
  end

  assign q_o = sync_q[DEPTH-1];

endmodule

// File: rtl/async_queue_sink_ctrl.sv
// Sink side of the single-entry hart-control async queue: synchronizes the
// source's gray write index and alive flags, presents each entry once.
module async_queue_sink_ctrl
  import debug_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_DEPTH = SYNC_DEPTH_DEFAULT
) (
  input logic                    clock,
  input logic                    reset_n,
  async_queue_sink_ctrl_if.slave bus
);

  logic         link_rst_n;
  logic         widx_sync;
  logic         sink_valid_0;
  logic         sink_valid_1;
  logic         source_extend;
  logic         source_ready;
  logic         deq_valid;
  logic         fire;
  logic         ridx_next;
  logic         valid;
  logic         ridx_bin_q, ridx_bin_d;
  logic         valid_q;
  logic         ridx_out_q;
  ctrl_bundle_t mem_w;
  ctrl_bundle_t bits_q;

  // Link-side flags drop as soon as either end is in reset.
  assign link_rst_n = reset_n & bus.io_async_safe_source_reset_n;

  async_sync_reg #(.DEPTH(SYNC_DEPTH)) u_widx_sync (
    .clk_i(clock), .rst_ni(reset_n), .d_i(bus.io_async_widx), .q_o(widx_sync));
  async_sync_reg #(.DEPTH(SYNC_DEPTH)) u_sink_valid_0 (
    .clk_i(clock), .rst_ni(link_rst_n), .d_i(1'b1), .q_o(sink_valid_0));
  async_sync_reg #(.DEPTH(SYNC_DEPTH)) u_sink_valid_1 (
    .clk_i(clock), .rst_ni(link_rst_n), .d_i(sink_valid_0), .q_o(sink_valid_1));
  async_sync_reg #(.DEPTH(SYNC_DEPTH)) u_source_extend (
    .clk_i(clock), .rst_ni(link_rst_n), .d_i(bus.io_async_safe_widx_valid), .q_o(source_extend));
  async_sync_reg #(.DEPTH(SYNC_DEPTH)) u_source_valid (
    .clk_i(clock), .rst_ni(reset_n), .d_i(source_extend), .q_o(source_ready));

  assign mem_w.resumereq    = bus.io_async_mem_0_resumereq;
  assign mem_w.hartsel      = bus.io_async_mem_0_hartsel;
  assign mem_w.ackhavereset = bus.io_async_mem_0_ackhavereset;
  assign mem_w.hasel        = bus.io_async_mem_0_hasel;
  assign mem_w.hamask = {bus.io_async_mem_0_hamask_5, bus.io_async_mem_0_hamask_4,
                         bus.io_async_mem_0_hamask_3, bus.io_async_mem_0_hamask_2,
                         bus.io_async_mem_0_hamask_1, bus.io_async_mem_0_hamask_0};
  assign mem_w.hrmask = {bus.io_async_mem_0_hrmask_5, bus.io_async_mem_0_hrmask_4,
                         bus.io_async_mem_0_hrmask_3, bus.io_async_mem_0_hrmask_2,
                         bus.io_async_mem_0_hrmask_1, bus.io_async_mem_0_hrmask_0};

  // Dequeue handshake: a beat transfers on a clock edge where io_deq_valid and
  // io_deq_ready are both high; valid never looks at ready combinationally and,
  // once raised, holds with stable bits until that transfer or a source reset.
  // ridx_next already counts the beat firing now, so the drained entry cannot
  // re-raise valid and a newly landed widx toggle is seen the cycle after.
  always_comb begin
    deq_valid  = valid_q & source_ready;
    fire       = deq_valid & bus.io_deq_ready;
    ridx_next  = ridx_bin_q ^ fire;
    valid      = source_ready & (ridx_next != widx_sync);
    ridx_bin_d = source_ready ? ridx_next : 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ridx_bin_q <= 1'b0;
      valid_q    <= 1'b0;
      ridx_out_q <= 1'b0;
    end else begin
      ridx_bin_q <= ridx_bin_d;
      valid_q    <= valid;
      ridx_out_q <= ridx_next;
    end
  end

  // Payload is a plain data register: no reset, refreshed while an entry is pending.
  always_ff @(posedge clock) begin
    if (valid) bits_q <= mem_w;
  end

  assign bus.io_deq_valid             = deq_valid;
  assign bus.io_deq_bits_resumereq    = bits_q.resumereq;
  assign bus.io_deq_bits_hartsel      = bits_q.hartsel;
  assign bus.io_deq_bits_ackhavereset = bits_q.ackhavereset;
  assign bus.io_deq_bits_hasel        = bits_q.hasel;
  assign bus.io_deq_bits_hamask_0     = bits_q.hamask[0];
  assign bus.io_deq_bits_hamask_1     = bits_q.hamask[1];
  assign bus.io_deq_bits_hamask_2     = bits_q.hamask[2];
  assign bus.io_deq_bits_hamask_3     = bits_q.hamask[3];
  assign bus.io_deq_bits_hamask_4     = bits_q.hamask[4];
  assign bus.io_deq_bits_hamask_5     = bits_q.hamask[5];
  assign bus.io_deq_bits_hrmask_0     = bits_q.hrmask[0];
  assign bus.io_deq_bits_hrmask_1     = bits_q.hrmask[1];
  assign bus.io_deq_bits_hrmask_2     = bits_q.hrmask[2];
  assign bus.io_deq_bits_hrmask_3     = bits_q.hrmask[3];
  assign bus.io_deq_bits_hrmask_4     = bits_q.hrmask[4];
  assign bus.io_deq_bits_hrmask_5     = bits_q.hrmask[5];
  assign bus.io_async_ridx              = ridx_out_q;
  assign bus.io_async_safe_ridx_valid   = sink_valid_1;
  assign bus.io_async_safe_sink_reset_n = reset_n;
  assign bus.dbg_source_ready           = source_ready;
  assign bus.dbg_ridx_bin               = ridx_bin_q;

endmodule
